// File: rtl/arith_engine.sv
// Iterative arithmetic back end: add/sub in one cycle, shift-add multiply and
// restoring divide in WIDTH cycles. Results stay frozen in HOLD until relaunch.
module arith_engine #(
    parameter int WIDTH = 18
) (
    input  logic               freq625m,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   num1,
    input  logic [WIDTH-1:0]   num2,
    input  logic [1:0]         op,
    output logic [2*WIDTH-1:0] result,
    output logic [WIDTH-1:0]   remainder,
    output logic               negative,
    output logic               div_err,
    output logic               busy,
    output logic               valid
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic [1:0]         state;
    logic               start_d;
    logic [WIDTH-1:0]   a_reg;   // add/sub operand; dividend shift register for div
    logic [WIDTH-1:0]   b_reg;   // add/sub operand and divisor; multiplier shift register for mul
    logic [1:0]         op_reg;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;     // product accumulator, or quotient in the low bits
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   prem;

    logic               launch;
    logic               finish;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic               fits;
    logic [WIDTH-1:0]   prem_next;
    logic [WIDTH-1:0]   quot_next;

    assign launch = start && !start_d && (state != CALC);

    assign sum      = {1'b0, a_reg} + {1'b0, b_reg};
    assign acc_next = b_reg[0] ? acc + mcand : acc;

    // Restoring step: shift in the next dividend bit, subtract if the divisor fits.
    assign trial     = {prem, a_reg[WIDTH-1]};
    assign diff      = trial - {1'b0, b_reg};
    assign fits      = (trial >= {1'b0, b_reg});
    assign prem_next = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quot_next = {acc[WIDTH-2:0], fits};

    assign finish = (state == CALC) &&
                    ((op_reg == OP_ADD) || (op_reg == OP_SUB) ||
                     ((op_reg == OP_DIV) && (b_reg == '0)) ||
                     (cnt == LAST));

    // NOTE: every register here, including the operand/work registers, is cleared
    // by the synchronous reset so a mid-computation abort leaves no stale state.
    always_ff @(posedge freq625m) begin
        if (!reset_n) begin
            state     <= IDLE;
            start_d   <= 1'b1;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            prem      <= '0;
            result    <= '0;
            remainder <= '0;
            negative  <= 1'b0;
            div_err   <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            start_d <= start;
            case (state)
                IDLE, HOLD: begin
                    if (launch) begin
                        a_reg    <= num1;
                        b_reg    <= num2;
                        op_reg   <= op;
                        cnt      <= '0;
                        acc      <= '0;
                        mcand    <= {{WIDTH{1'b0}}, num1};
                        prem     <= '0;
                        negative <= 1'b0;
                        div_err  <= 1'b0;
                        valid    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    case (op_reg)
                        OP_ADD: begin
                            result    <= {{(WIDTH-1){1'b0}}, sum};
                            remainder <= '0;
                        end
                        OP_SUB: begin
                            remainder <= '0;
                            if (a_reg >= b_reg) begin
                                result <= {{WIDTH{1'b0}}, a_reg - b_reg};
                            end else begin
                                result   <= {{WIDTH{1'b0}}, b_reg - a_reg};
                                negative <= 1'b1;
                            end
                        end
                        OP_MUL: begin
                            acc   <= acc_next;
                            mcand <= {mcand[2*WIDTH-2:0], 1'b0};
                            b_reg <= b_reg >> 1;
                            cnt   <= cnt + CW'(1);
                            if (cnt == LAST) begin
                                result    <= acc_next;
                                remainder <= '0;
                            end
                        end
                        default: begin
                            if (b_reg == '0) begin
                                div_err   <= 1'b1;
                                result    <= '0;
                                remainder <= a_reg;
                            end else begin
                                a_reg <= {a_reg[WIDTH-2:0], 1'b0};
                                prem  <= prem_next;
                                acc   <= {{WIDTH{1'b0}}, quot_next};
                                cnt   <= cnt + CW'(1);
                                if (cnt == LAST) begin
                                    result    <= {{WIDTH{1'b0}}, quot_next};
                                    remainder <= prem_next;
                                end
                            end
                        end
                    endcase
                    if (finish) begin
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        state <= HOLD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_engine.sv
// Self-checking bench for arith_engine: directed scenarios plus random operations
// compared against a plain-arithmetic reference model.
module tb_arith_engine;

    logic        freq625m = 1'b0;
    logic        reset_n  = 1'b0;
    logic        start    = 1'b0;
    logic [17:0] num1     = '0;
    logic [17:0] num2     = '0;
    logic [1:0]  op       = '0;
    logic [35:0] result;
    logic [17:0] remainder;
    logic        negative;
    logic        div_err;
    logic        busy;
    logic        valid;

    int n_checks   = 0;
    int n_fail     = 0;
    int excl_viol  = 0;

    arith_engine #(.WIDTH(18)) dut (
        .freq625m (freq625m),
        .reset_n  (reset_n),
        .start    (start),
        .num1     (num1),
        .num2     (num2),
        .op       (op),
        .result   (result),
        .remainder(remainder),
        .negative (negative),
        .div_err  (div_err),
        .busy     (busy),
        .valid    (valid)
    );

    always #5 freq625m = ~freq625m;

    always @(negedge freq625m) begin
        if (busy && valid) excl_viol++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model straight from the arithmetic definitions.
    task automatic model(input logic [17:0] a, input logic [17:0] b, input logic [1:0] o,
                         output logic [63:0] r, output logic [63:0] rm,
                         output logic ng, output logic er, output int lat);
        r = 0; rm = 0; ng = 0; er = 0; lat = 18;
        case (o)
            2'b00: begin r = 64'(a) + 64'(b); lat = 1; end
            2'b01: begin
                lat = 1;
                if (a < b) begin r = 64'(b) - 64'(a); ng = 1; end
                else r = 64'(a) - 64'(b);
            end
            2'b10: r = 64'(a) * 64'(b);
            default: begin
                if (b == 0) begin er = 1; r = 0; rm = 64'(a); lat = 1; end
                else begin r = 64'(a) / 64'(b); rm = 64'(a) % 64'(b); end
            end
        endcase
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".result"}, 64'(result), 0);
        check({tag, ".remainder"}, 64'(remainder), 0);
        check({tag, ".flags"}, {60'd0, negative, div_err, busy, valid}, 0);
    endtask

    // Launch one operation, optionally raise a second start edge at T<glitch>,
    // wait (bounded) for valid and compare everything against the model.
    task automatic run_op(input string tag, input logic [17:0] a, input logic [17:0] b,
                          input logic [1:0] o, input int glitch);
        logic [63:0] er_r, er_rm;
        logic        e_ng, e_er;
        int          e_lat;
        int          cycles;
        logic        done;
        logic [35:0] held;
        model(a, b, o, er_r, er_rm, e_ng, e_er, e_lat);
        @(negedge freq625m);
        num1 = a; num2 = b; op = o; start = 1'b1;
        @(posedge freq625m);
        @(negedge freq625m);
        start = 1'b0;
        num1 = 18'($urandom); num2 = 18'($urandom); op = 2'($urandom);
        check({tag, ".t0_busy_valid"}, {62'd0, busy, valid}, 64'b10);
        cycles = 0; done = 1'b0;
        while (!done && cycles < 40) begin
            if (cycles + 1 == glitch) start = 1'b1;
            @(posedge freq625m);
            @(negedge freq625m);
            cycles++;
            start = 1'b0;
            if (valid) done = 1'b1;
        end
        check({tag, ".latency"}, 64'(cycles), 64'(e_lat));
        check({tag, ".result"}, 64'(result), er_r);
        check({tag, ".remainder"}, 64'(remainder), er_rm);
        check({tag, ".neg_err"}, {62'd0, negative, div_err}, {62'd0, e_ng, e_er});
        check({tag, ".busy"}, 64'(busy), 0);
        held = result;
        repeat (2) @(negedge freq625m);
        check({tag, ".held"}, {28'd0, result, valid}, {28'd0, held, 1'b1});
    endtask

    task automatic do_reset();
        @(negedge freq625m);
        reset_n = 1'b0;
        repeat (3) @(posedge freq625m);
        @(negedge freq625m);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [17:0] ra, rb;
        logic [1:0]  ro;

        do_reset();
        check_all_zero("reset_state");

        run_op("add_carry", 18'd262143, 18'd1, 2'b00, 0);
        run_op("sub_neg", 18'd5, 18'd9, 2'b01, 0);
        run_op("sub_pos", 18'd9, 18'd5, 2'b01, 0);
        run_op("mul_max", 18'd262143, 18'd262143, 2'b10, 5);
        check("mul_max_literal", 64'(result), 64'd68718952449);
        run_op("div", 18'd100000, 18'd7, 2'b11, 0);
        check("div_literal", {28'd0, result}, {28'd0, 36'd14285});
        run_op("div_zero", 18'd1234, 18'd0, 2'b11, 0);
        run_op("add_after_div", 18'd3, 18'd4, 2'b00, 0);

        // Start held high through reset release must not launch.
        @(negedge freq625m);
        reset_n = 1'b0; start = 1'b1; num1 = 18'd1; num2 = 18'd2; op = 2'b00;
        repeat (3) @(posedge freq625m);
        @(negedge freq625m);
        reset_n = 1'b1;
        repeat (5) @(negedge freq625m);
        check("held_start.busy_valid", {62'd0, busy, valid}, 0);
        start = 1'b0;
        @(negedge freq625m);
        run_op("held_start_relaunch", 18'd1000, 18'd2345, 2'b00, 0);

        // Reset at T9 of a multiply.
        run_op("pre_abort", 18'd77, 18'd12, 2'b11, 0);
        @(negedge freq625m);
        num1 = 18'd4321; num2 = 18'd999; op = 2'b10; start = 1'b1;
        @(posedge freq625m);
        @(negedge freq625m);
        start = 1'b0;
        repeat (8) @(posedge freq625m);
        @(negedge freq625m);
        reset_n = 1'b0;
        @(posedge freq625m);
        @(negedge freq625m);
        check_all_zero("mid_reset");
        reset_n = 1'b1;
        run_op("post_abort_mul", 18'd4321, 18'd999, 2'b10, 0);

        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 18'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 18'($urandom_range(1, 15));
                2:       rb = ra;
                default: rb = 18'($urandom);
            endcase
            run_op($sformatf("rand%0d", i), ra, rb, ro, ($urandom_range(0, 3) == 0) ? 3 : 0);
        end

        check("busy_valid_exclusive", 64'(excl_viol), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arith_engine.md
# arith_engine

Arithmetic back end for the calculator datapath. Consumes the two 18-bit unsigned operands and the `done` strobe produced by the number-entry stage, then computes add, subtract, multiply or divide with an iterative shift-add/restoring datapath. Results are held stable for the display stage until the next launch.

## Interface

Parameters:
- `WIDTH`, 18: operand width in bits. Result width is 2×WIDTH.

Ports:
- `freq625m`  in  1  system clock (6.25 MHz). Single clock domain.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  launch request. Driven by the entry stage's `done`, which may be a pulse or a level; only its rising edge counts.
- `num1`  in  18  operand A, unsigned.
- `num2`  in  18  operand B, unsigned.
- `op`  in  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- `result`  out  36  sum, difference magnitude, product or quotient, zero-extended.
- `remainder`  out  18  division remainder; 0 for all other operations.
- `negative`  out  1  subtraction result is negative (num1 < num2).
- `div_err`  out  1  division by zero.
- `busy`  out  1  iterative computation in progress.
- `valid`  out  1  result fields are final and stable.

## Operation

- **Edge detect:** register `start_d` follows `start` every cycle.
  - A launch requires `start`=1 and `start_d`=0.
  - `start_d` resets to 1, so a `start` held high through reset release does not launch; it must go low first.
- **FSM states:** IDLE, CALC, HOLD.
- **IDLE / HOLD + launch:**
  - Capture `num1`, `num2` and `op` into internal registers; clear the iteration counter.
  - Clear `valid`, `negative`, `div_err`; set `busy`=1; go to CALC.
  - `result` and `remainder` keep their old values until they are overwritten at completion.
- **CALC, add:** `result` = A+B (19 significant bits; carry lands in bit 18). Go to HOLD.
- **CALC, sub:**
  - A≥B: `result` = A−B, `negative`=0.
  - A<B: `result` = B−A, `negative`=1.
  - Go to HOLD.
- **CALC, mul:** 18-iteration shift-add, one multiplier bit per cycle, LSB first.
  - 36-bit accumulator.
  - On iteration 17, write the product to `result`. Go to HOLD.
- **CALC, div:** 18-iteration restoring division, one quotient bit per cycle, MSB first.
  - On completion, `result` = {18'b0, quotient} and `remainder` = partial remainder. Go to HOLD.
  - If B==0: in the first CALC cycle, set `div_err`=1, `result`=0, `remainder`=A, and go to HOLD. No iterations run.
- **Entering HOLD:** `busy`=0, `valid`=1. All outputs are held until the next launch or reset.
- **Launch while in CALC:** ignored. Operands and `op` changing during CALC have no effect.
- **Reset:** `reset_n`=0 at any clock edge, including mid-CALC:
  - State → IDLE; the computation is abandoned.
  - All outputs → 0; internal registers → 0; `start_d` → 1.

## Timing

- **T0** = the clock edge that samples a launch. After T0: `busy`=1, `valid`=0.
- **Add, sub, div-by-zero:** complete at T1. After T1: `valid`=1, `busy`=0.
- **Mul, div:** complete at T18 (18 CALC cycles, T1..T18). After T18: `valid`=1, `busy`=0.
- **Back-to-back launches:** a launch sampled in HOLD at Tn behaves exactly like T0. `valid` is low for at least one cycle between results.
- **Invariant:** `busy` and `valid` are never both 1.
- **No backpressure:** the consumer samples results while `valid`=1.

## Test plan

- **Add with carry:** reset, then `num1`=262143, `num2`=1, `op`=00, pulse `start` → `result`=262144, `valid` high after T1, `busy` high for exactly 1 cycle.
- **Subtract, negative:** `num1`=5, `num2`=9, `op`=01 → `result`=4, `negative`=1. Then relaunch with 9−5 → `result`=4, `negative`=0.
- **Multiply, maximum operands:** `num1`=`num2`=262143, `op`=10 → `result`=68718952449, `valid` after T18. A second `start` edge at T5 is ignored and the result is unchanged.
- **Divide and divide-by-zero:**
  - 100000 / 7, `op`=11 → `result`=14285, `remainder`=5, at T18.
  - 1234 / 0 → `div_err`=1, `result`=0, `remainder`=1234, at T1.
- **Held start across reset:** hold `start`=1 through reset release → no launch, `valid` stays 0. Drop `start` and raise it again → launch occurs.
- **Reset mid-computation:** launch a multiply, assert `reset_n`=0 at T9 → next cycle all outputs are 0 and the FSM is in IDLE. A fresh launch afterwards completes correctly.
